// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes vs. a 2-entry long-latency result queue, registered outputs (1 cycle).
// l_ready deasserts when the queue is full; a starved queue forces one stall_p cycle, and a pipeline write in that cycle is dropped (err).
module wb_arbiter (
    input  logic        clk,
    input  logic        clrn,
    input  logic        p_we,
    input  logic [4:0]  p_wn,
    input  logic [31:0] p_d,
    input  logic        l_valid,
    input  logic [4:0]  l_wn,
    input  logic [31:0] l_d,
    output logic        l_ready,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    output logic        we,
    output logic [4:0]  wn,
    output logic [31:0] d,
    output logic        haz_a,
    output logic        haz_b,
    output logic        stall_p,
    output logic        err
);

    typedef struct packed {
        logic [4:0]  wn;
        logic [31:0] d;
    } wr_t;

    logic        we_q, we_d;
    logic [4:0]  wn_q, wn_d;
    logic [31:0] d_q, d_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    wr_t         ent_q [2];
    wr_t         ent_d [2];
    logic [2:0]  starve_q, starve_d;
    logic        stall_q, stall_d;
    logic        err_q, err_d;

    logic        p_req, fifo_ne, push, pop, load_p;
    logic [1:0]  slot_vld;
    wr_t         head;

    always_comb begin
        p_req   = p_we && (p_wn != 5'd0);
        fifo_ne = (count_q != 2'd0);
        l_ready = (count_q != 2'd2);
        push    = l_valid && l_ready && (l_wn != 5'd0);
        // A forced stall always pops; otherwise the pipeline wins over the queue.
        pop     = fifo_ne && (stall_q || !p_req);
        load_p  = p_req && !stall_q && !pop;
        head    = ent_q[rd_ptr_q];

        we_d = 1'b0;
        wn_d = wn_q;
        d_d  = d_q;
        if (pop) begin
            we_d = 1'b1;
            wn_d = head.wn;
            d_d  = head.d;
        end else if (load_p) begin
            we_d = 1'b1;
            wn_d = p_wn;
            d_d  = p_d;
        end

        err_d = err_q || (p_req && stall_q);

        ent_d = ent_q;
        if (push) begin
            ent_d[wr_ptr_q].wn = l_wn;
            ent_d[wr_ptr_q].d  = l_d;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        starve_d = (fifo_ne && !pop) ? starve_q + 3'd1 : 3'd0;
        stall_d  = fifo_ne && !pop && (starve_q == 3'd6);

        slot_vld[0] = (count_q == 2'd2) || ((count_q == 2'd1) && !rd_ptr_q);
        slot_vld[1] = (count_q == 2'd2) || ((count_q == 2'd1) && rd_ptr_q);
    end

    function automatic logic hit(input logic [4:0] rn);
        return (rn != 5'd0) &&
               ((we_q && (wn_q == rn)) ||
                (slot_vld[0] && (ent_q[0].wn == rn)) ||
                (slot_vld[1] && (ent_q[1].wn == rn)));
    endfunction

    assign haz_a   = hit(rna);
    assign haz_b   = hit(rnb);
    assign we      = we_q;
    assign wn      = wn_q;
    assign d       = d_q;
    assign stall_p = stall_q;
    assign err     = err_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            we_q     <= 1'b0;
            wn_q     <= 5'd0;
            d_q      <= 32'd0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            starve_q <= 3'd0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            wn_q     <= wn_d;
            d_q      <= d_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ent_q    <= ent_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change 1 time unit after a rising edge, outputs are checked there.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        clrn;
    logic        p_we, l_valid, l_ready;
    logic [4:0]  p_wn, l_wn, rna, rnb, wn;
    logic [31:0] p_d, l_d, d;
    logic        we, haz_a, haz_b, stall_p, err;

    int total = 0;
    int bad   = 0;

    wb_arbiter dut (
        .clk(clk), .clrn(clrn),
        .p_we(p_we), .p_wn(p_wn), .p_d(p_d),
        .l_valid(l_valid), .l_wn(l_wn), .l_d(l_d), .l_ready(l_ready),
        .rna(rna), .rnb(rnb),
        .we(we), .wn(wn), .d(d),
        .haz_a(haz_a), .haz_b(haz_b), .stall_p(stall_p), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn = 1'b1;
        p_we = 0; p_wn = 0; p_d = 0;
        l_valid = 0; l_wn = 0; l_d = 0;
        rna = 5'd9; rnb = 5'd0;
        #1 clrn = 1'b0;
        #10;
        chk("rst_we", we, 0);
        chk("rst_wn", wn, 0);
        chk("rst_d", d, 0);
        chk("rst_l_ready", l_ready, 1);
        chk("rst_haz_a", haz_a, 0);
        chk("rst_stall", stall_p, 0);
        chk("rst_err", err, 0);
        clrn = 1'b1;

        // Pipeline write, then idle with held wn/d
        p_we = 1; p_wn = 5'd5; p_d = 32'h1234;
        step();
        chk("pw_we", we, 1);
        chk("pw_wn", wn, 5);
        chk("pw_d", d, 32'h1234);
        p_we = 0;
        step();
        chk("pw_idle_we", we, 0);
        chk("pw_hold_wn", wn, 5);
        chk("pw_hold_d", d, 32'h1234);

        // Long path with hazard tracking
        l_valid = 1; l_wn = 5'd9; l_d = 32'hCAFE; rna = 5'd9; rnb = 5'd8;
        chk("lp_ready", l_ready, 1);
        step();
        l_valid = 0;
        #1;
        chk("lp_haz_fifo", haz_a, 1);
        chk("lp_haz_b", haz_b, 0);
        chk("lp_we_c2", we, 0);
        step();
        chk("lp_we_c3", we, 1);
        chk("lp_wn_c3", wn, 9);
        chk("lp_d_c3", d, 32'hCAFE);
        chk("lp_haz_wn", haz_a, 1);
        step();
        chk("lp_we_c4", we, 0);
        chk("lp_haz_c4", haz_a, 0);

        // r0 suppression on both paths
        p_we = 1; p_wn = 5'd0; p_d = 32'hDEAD;
        l_valid = 1; l_wn = 5'd0; l_d = 32'hBEEF;
        step();
        chk("r0_we", we, 0);
        chk("r0_ready", l_ready, 1);
        p_we = 0; l_valid = 0;
        step();
        chk("r0_we2", we, 0);
        chk("r0_wn_hold", wn, 9);

        // FIFO full while pipeline writes every cycle
        p_we = 1; p_wn = 5'd10; p_d = 32'hA0;
        l_valid = 1; l_wn = 5'd3; l_d = 32'h3333;
        step();
        chk("ff_wn10", wn, 10);
        chk("ff_ready1", l_ready, 1);
        p_wn = 5'd11; l_wn = 5'd4; l_d = 32'h4444;
        step();
        chk("ff_wn11", wn, 11);
        chk("ff_ready_full", l_ready, 0);
        p_wn = 5'd12; l_wn = 5'd5; l_d = 32'h5555;
        step();
        chk("ff_wn12", wn, 12);
        chk("ff_still_full", l_ready, 0);
        rna = 5'd4; rnb = 5'd5;
        #1;
        chk("ff_haz_4", haz_a, 1);
        chk("ff_haz_5", haz_b, 0);
        p_we = 0; l_valid = 0;
        step();
        chk("ff_pop1_we", we, 1);
        chk("ff_pop1_wn", wn, 3);
        chk("ff_pop1_d", d, 32'h3333);
        chk("ff_ready_after", l_ready, 1);
        step();
        chk("ff_pop2_wn", wn, 4);
        chk("ff_pop2_d", d, 32'h4444);
        step();
        chk("ff_empty_we", we, 0);
        chk("ff_no5", haz_b, 0);

        // Starvation: reg 7 queued behind continuous pipeline writes
        p_we = 1; p_wn = 5'd20; p_d = 32'h20;
        l_valid = 1; l_wn = 5'd7; l_d = 32'h7777;
        step();
        chk("sv_wn20", wn, 20);
        chk("sv_stall0", stall_p, 0);
        l_valid = 0;
        for (int i = 1; i <= 7; i++) begin
            p_wn = 5'(20 + i); p_d = 32'(i);
            step();
            chk("sv_wn", wn, 20 + i);
            chk("sv_stall", stall_p, (i == 7));
        end
        chk("sv_err_pre", err, 0);
        p_wn = 5'd30; p_d = 32'h30;
        step();
        chk("sv_pop_we", we, 1);
        chk("sv_pop_wn", wn, 7);
        chk("sv_pop_d", d, 32'h7777);
        chk("sv_stall_clr", stall_p, 0);
        chk("sv_err", err, 1);
        p_we = 0;
        step();
        chk("sv_err_sticky", err, 1);
        chk("sv_dropped", we, 0);

        // Reset mid-operation with count=2 and we=1
        p_we = 1; p_wn = 5'd13; p_d = 32'h13;
        l_valid = 1; l_wn = 5'd12; l_d = 32'h12;
        step();
        l_wn = 5'd14; l_d = 32'h14;
        step();
        chk("mr_we_pre", we, 1);
        chk("mr_full_pre", l_ready, 0);
        p_we = 0; l_valid = 0; rna = 5'd12;
        #2 clrn = 1'b0;
        #1;
        chk("mr_we", we, 0);
        chk("mr_ready", l_ready, 1);
        chk("mr_haz", haz_a, 0);
        chk("mr_err", err, 0);
        #2 clrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_write", we, 0);
            chk("mr_ready_after", l_ready, 1);
        end
        p_we = 1; p_wn = 5'd6; p_d = 32'h66;
        step();
        chk("mr_first_we", we, 1);
        chk("mr_first_wn", wn, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
